// File: rtl/imem_loader_pkg.sv
// Shared definitions for the instruction-memory program loader.
// State encoding, stream-format constants and a busy-state helper.
package imem_loader_pkg;

  typedef enum logic [2:0] {
    HDR0 = 3'd0,
    HDR1 = 3'd1,
    DATA = 3'd2,
    CSUM = 3'd3,
    DONE = 3'd4,
    ERR  = 3'd5
  } loader_state_e;

  localparam logic [2:0] ST_HDR0 = 3'd0;
  localparam logic [2:0] ST_HDR1 = 3'd1;
  localparam logic [2:0] ST_DATA = 3'd2;
  localparam logic [2:0] ST_CSUM = 3'd3;
  localparam logic [2:0] ST_DONE = 3'd4;
  localparam logic [2:0] ST_ERR  = 3'd5;

  localparam int HDR_BYTES      = 2;
  localparam int BYTES_PER_WORD = 4;

  function automatic logic is_busy(input logic [2:0] st);
    return (st inside {ST_HDR0, ST_HDR1, ST_DATA, ST_CSUM});
  endfunction

endpackage

// File: rtl/imem_word_packer.sv
// Packs a little-endian byte stream into 32-bit words.
// done_o and word_o are combinational on the byte that completes a word.
module imem_word_packer
  import imem_loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clear_i,
  input  logic        byte_en_i,
  input  logic [7:0]  byte_i,
  output logic [31:0] word_o,
  output logic        done_o
);

  localparam logic [1:0] LAST_BYTE = 2'(BYTES_PER_WORD - 1);

  logic [1:0]  cnt_q;
  logic [31:0] shift_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      shift_q <= '0;
    end else if (clear_i) begin
      cnt_q   <= '0;
      shift_q <= '0;
    end else if (byte_en_i) begin
      cnt_q   <= cnt_q + 2'd1;
      shift_q <= {byte_i, shift_q[31:8]};
    end
  end

  assign word_o = {byte_i, shift_q[31:8]};
  assign done_o = byte_en_i && (cnt_q == LAST_BYTE);

endmodule

// File: rtl/imem_loader.sv
// Streams a length-prefixed byte image into instruction memory, holding the core in reset until done.
// Optional trailing XOR checksum byte is enabled with IMEM_LOADER_CHECKSUM_EN.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int IMEM_DEPTH = 256,
  parameter int ADDR_W     = $clog2(IMEM_DEPTH)
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  input  logic              load_req,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_waddr,
  output logic [31:0]       imem_wdata,
  output logic              core_resetn,
  output logic              busy,
  output logic              error,
  output logic [15:0]       words_loaded
);

`ifdef IMEM_LOADER_CHECKSUM_EN
  localparam logic [2:0] ST_POST = ST_CSUM;
`else
  localparam logic [2:0] ST_POST = ST_DONE;
`endif

  logic [2:0]        state_q, state_d;
  logic [15:0]       n_q, n_d;
  logic [15:0]       words_q, words_d;
  logic              we_q;
  logic [ADDR_W-1:0] waddr_q;
  logic [31:0]       wdata_q;
  logic              core_rst_q;

  logic        xfer;
  logic        reload;
  logic        pk_en;
  logic        pk_done;
  logic [31:0] pk_word;
  logic [15:0] hdr_n;

  assign in_ready = is_busy(state_q);
  assign xfer     = in_valid && in_ready;
  assign reload   = load_req && ((state_q == ST_DONE) || (state_q == ST_ERR));
  assign hdr_n    = {in_data, n_q[7:0]};
  // Bytes arriving while the last word's write is in flight are dropped.
  assign pk_en    = xfer && (state_q == ST_DATA) && (words_q != n_q);

  imem_word_packer u_packer (
    .clk       (clk),
    .rst_n     (resetn),
    .clear_i   (reload),
    .byte_en_i (pk_en),
    .byte_i    (in_data),
    .word_o    (pk_word),
    .done_o    (pk_done)
  );

`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0] csum_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)     csum_q <= '0;
    else if (reload) csum_q <= '0;
    else if (pk_en)  csum_q <= csum_q ^ in_data;
  end
`endif

  always_comb begin
    state_d = state_q;
    n_d     = n_q;
    words_d = words_q;
    case (state_q)
      ST_HDR0: if (xfer) begin
        n_d     = {8'h00, in_data};
        state_d = ST_HDR1;
      end
      ST_HDR1: if (xfer) begin
        n_d = hdr_n;
        if (hdr_n == 16'd0)                        state_d = ST_POST;
        else if ({1'b0, hdr_n} > 17'(IMEM_DEPTH))  state_d = ST_ERR;
        else                                       state_d = ST_DATA;
      end
      ST_DATA: begin
        if (pk_done) words_d = words_q + 16'd1;
        // Leave only once the final word's write cycle is on the port.
        if (we_q && (words_q == n_q)) state_d = ST_POST;
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      ST_CSUM: if (xfer) state_d = (in_data == csum_q) ? ST_DONE : ST_ERR;
`endif
      ST_DONE, ST_ERR: if (load_req) begin
        state_d = ST_HDR0;
        words_d = '0;
      end
      default: state_d = ST_HDR0;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= ST_HDR0;
      n_q        <= '0;
      words_q    <= '0;
      we_q       <= 1'b0;
      waddr_q    <= '0;
      wdata_q    <= '0;
      core_rst_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      n_q        <= n_d;
      words_q    <= words_d;
      we_q       <= pk_done;
      core_rst_q <= (state_d == ST_DONE);
      if (pk_done) begin
        waddr_q <= words_q[ADDR_W-1:0];
        wdata_q <= pk_word;
      end
    end
  end

  assign imem_we      = we_q;
  assign imem_waddr   = waddr_q;
  assign imem_wdata   = wdata_q;
  assign core_resetn  = core_rst_q;
  assign busy         = is_busy(state_q);
  assign error        = (state_q == ST_ERR);
  assign words_loaded = words_q;

endmodule
